// File: rtl/fattree_port_allocator.sv
// Switch allocator for one fat-tree router: round-robin per output, wormhole lock until tail,
// per-output credit tracking, registered crossbar select.
module fattree_port_allocator #(
  parameter int K            = 4,
  parameter int CREDIT_DEPTH = 4,
  localparam int P  = 2 * K,
  localparam int PW = $clog2(P),
  localparam int CW = $clog2(CREDIT_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [P-1:0]         in_valid,
  input  logic [P-1:0]         in_hdr,
  input  logic [P-1:0]         in_tail,
  input  logic [P*(K+1)-1:0]   in_destport,
  input  logic [P-1:0]         credit_in,
  output logic [P-1:0]         in_grant,
  output logic [P-1:0]         out_valid,
  output logic [P*PW-1:0]      out_sel,
  output logic [P-1:0]         out_locked,
  output logic                 err
);

  // state     | meaning
  // ST_IDLE   | output free, arbitrates among head flits
  // ST_LOCKED | output owned by owner[o] until its tail flit is granted
  localparam logic ST_IDLE   = 1'b0;
  localparam logic ST_LOCKED = 1'b1;

  logic [P-1:0]          state;
  logic [P-1:0][PW-1:0]  owner;
  logic [P-1:0][PW-1:0]  ptr;
  logic [P-1:0][CW-1:0]  credit;

  logic [P-1:0]          legal;
  logic [P-1:0][P-1:0]   req;    // req[o][i]: input i targets output o
  logic [P-1:0][P-1:0]   cand;
  logic [P-1:0]          owned;
  logic [P-1:0][P-1:0]   gnt;    // gnt[o][i]
  logic [P-1:0][PW-1:0]  win;
  logic [P-1:0]          out_gnt;
  logic [PW-1:0]         rr_idx;
  logic                  found;

  always_comb begin
    legal = '0;
    req   = '0;
    for (int i = 0; i < P; i++) begin
      legal[i] = $onehot(in_destport[i*(K+1) +: K]);
      for (int j = 0; j < K; j++) begin
        if (legal[i] && in_destport[i*(K+1) + j]) begin
          req[(in_destport[i*(K+1) + K] ? K : 0) + j][i] = 1'b1;
        end
      end
    end
  end

  // An owner presenting a head mid-packet is a protocol error; keep it out of all arbitration.
  always_comb begin
    owned = '0;
    for (int o = 0; o < P; o++) begin
      if (state[o] == ST_LOCKED) owned[owner[o]] = 1'b1;
    end
    cand = '0;
    for (int o = 0; o < P; o++) begin
      cand[o] = req[o] & in_valid & in_hdr & ~owned;
    end
  end

  always_comb begin
    gnt     = '0;
    win     = '0;
    out_gnt = '0;
    rr_idx  = '0;
    found   = 1'b0;
    for (int o = 0; o < P; o++) begin
      if (credit[o] != '0) begin
        if (state[o] == ST_LOCKED) begin
          if (in_valid[owner[o]] && !in_hdr[owner[o]]) begin
            win[o]     = owner[o];
            out_gnt[o] = 1'b1;
          end
        end else begin
          found = 1'b0;
          for (int k = 0; k < P; k++) begin
            rr_idx = PW'((int'(ptr[o]) + k) % P);
            if (!found && cand[o][rr_idx]) begin
              found      = 1'b1;
              win[o]     = rr_idx;
              out_gnt[o] = 1'b1;
            end
          end
        end
      end
      if (out_gnt[o]) gnt[o][win[o]] = 1'b1;
    end
  end

  always_comb begin
    in_grant = '0;
    for (int o = 0; o < P; o++) begin
      in_grant = in_grant | gnt[o];
    end
  end

  assign out_locked = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= '0;
      owner     <= '0;
      ptr       <= '0;
      out_valid <= '0;
      out_sel   <= '0;
      err       <= 1'b0;
      for (int o = 0; o < P; o++) begin
        credit[o] <= CW'(CREDIT_DEPTH);
      end
    end else begin
      if (|(in_valid & ~legal)) err <= 1'b1;
      for (int o = 0; o < P; o++) begin
        out_valid[o] <= out_gnt[o];
        if (out_gnt[o]) begin
          out_sel[o*PW +: PW] <= win[o];
          if (state[o] == ST_LOCKED) begin
            if (in_tail[win[o]]) state[o] <= ST_IDLE;
          end else begin
            ptr[o] <= PW'((int'(win[o]) + 1) % P);
            if (!in_tail[win[o]]) begin
              state[o] <= ST_LOCKED;
              owner[o] <= win[o];
            end
          end
        end
        if (credit_in[o] && !out_gnt[o]) begin
          if (credit[o] == CW'(CREDIT_DEPTH)) err <= 1'b1;
          else credit[o] <= credit[o] + CW'(1);
        end else if (!credit_in[o] && out_gnt[o]) begin
          credit[o] <= credit[o] - CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_fattree_port_allocator.sv
// Directed bench for fattree_port_allocator: grants checked combinationally, registered outputs
// checked one cycle later against a queue of expected values.
module tb_fattree_port_allocator;
  localparam int K  = 4;
  localparam int P  = 2 * K;
  localparam int PW = $clog2(P);

  localparam logic [K:0] D_O0 = 5'b0_0001;
  localparam logic [K:0] D_O1 = 5'b0_0010;
  localparam logic [K:0] D_O2 = 5'b0_0100;
  localparam logic [K:0] D_O3 = 5'b0_1000;
  localparam logic [K:0] D_O5 = 5'b1_0010;

  logic               clk = 1'b0;
  logic               reset;
  logic [P-1:0]       v, h, t, cr;
  logic [K:0]         dp [P];
  logic [P*(K+1)-1:0] in_destport;
  logic [P-1:0]       in_grant, out_valid, out_locked;
  logic [P*PW-1:0]    out_sel;
  logic               err;

  typedef struct packed {
    logic [P-1:0]    ov;
    logic [P*PW-1:0] sel;
    logic [P-1:0]    lock;
  } exp_t;

  exp_t            exp_q[$];
  logic [P*PW-1:0] model_sel;
  int              checks = 0;
  int              errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    in_destport = '0;
    for (int i = 0; i < P; i++) in_destport[i*(K+1) +: K+1] = dp[i];
  end

  fattree_port_allocator #(.K(K), .CREDIT_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .in_valid(v), .in_hdr(h), .in_tail(t),
    .in_destport(in_destport), .credit_in(cr), .in_grant(in_grant),
    .out_valid(out_valid), .out_sel(out_sel), .out_locked(out_locked), .err(err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic int tgt_of(input logic [K:0] d);
    int o;
    o = -1;
    if ($onehot(d[K-1:0]))
      for (int j = 0; j < K; j++) if (d[j]) o = d[K] ? K + j : j;
    return o;
  endfunction

  task automatic clr();
    v = '0; h = '0; t = '0; cr = '0;
  endtask

  task automatic flit(input int i, input logic hdr, input logic tail, input logic [K:0] d);
    v[i] = 1'b1; h[i] = hdr; t[i] = tail; dp[i] = d;
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic cycle(input logic [P-1:0] exp_gnt, input logic [P-1:0] exp_lock, input string tag);
    exp_t e;
    int   o;
    #2;
    chk({tag, "/in_grant"}, 64'(in_grant), 64'(exp_gnt));
    e.ov   = '0;
    e.sel  = model_sel;
    e.lock = exp_lock;
    for (int i = 0; i < P; i++) begin
      if (exp_gnt[i]) begin
        o = tgt_of(dp[i]);
        if (o >= 0) begin
          e.ov[o] = 1'b1;
          e.sel[o*PW +: PW] = PW'(i);
        end
      end
    end
    model_sel = e.sel;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    e = exp_q.pop_front();
    chk({tag, "/out_valid"},  64'(out_valid),  64'(e.ov));
    chk({tag, "/out_sel"},    64'(out_sel),    64'(e.sel));
    chk({tag, "/out_locked"}, 64'(out_locked), 64'(e.lock));
  endtask

  initial begin
    reset = 1'b0;
    clr();
    for (int i = 0; i < P; i++) dp[i] = '0;
    model_sel = '0;
    #12;
    chk("rst_out_valid",  64'(out_valid),  64'h0);
    chk("rst_out_sel",    64'(out_sel),    64'h0);
    chk("rst_out_locked", 64'(out_locked), 64'h0);
    chk("rst_err",        64'(err),        64'h0);
    chk("rst_in_grant",   64'(in_grant),   64'h0);
    @(negedge clk);
    reset = 1'b1;

    // four credits: four single-flit grants to output 2, then stall
    clr(); flit(0, 1'b1, 1'b1, D_O2);
    for (int n = 0; n < 4; n++) cycle(8'h01, 8'h00, "t1_grant");
    cycle(8'h00, 8'h00, "t1_stall");
    clr();
    for (int n = 0; n < 4; n++) begin cr[2] = 1'b1; cycle(8'h00, 8'h00, "t1_refill"); end
    chk("t1_err", 64'(err), 64'h0);

    // contention on output 0: in0 holds it for 3 flits, then in1 wins the rotation
    clr(); flit(0, 1'b1, 1'b0, D_O0); flit(1, 1'b1, 1'b0, D_O0);
    cycle(8'h01, 8'h01, "t2_head");
    flit(0, 1'b0, 1'b0, D_O0);
    cycle(8'h01, 8'h01, "t2_body");
    flit(0, 1'b0, 1'b1, D_O0);
    cycle(8'h01, 8'h00, "t2_tail");
    flit(0, 1'b1, 1'b0, D_O0); flit(1, 1'b1, 1'b1, D_O0);
    cycle(8'h02, 8'h00, "t2_rr_in1");
    v[1] = 1'b0;
    cycle(8'h00, 8'h00, "t2_no_credit");
    clr();
    for (int n = 0; n < 4; n++) begin cr[0] = 1'b1; cycle(8'h00, 8'h00, "t2_refill"); end

    // 6-flit packet to output 5 starved of credits
    clr(); flit(2, 1'b1, 1'b0, D_O5);
    cycle(8'h04, 8'h20, "t3_head");
    flit(2, 1'b0, 1'b0, D_O5);
    for (int n = 0; n < 3; n++) cycle(8'h04, 8'h20, "t3_body");
    cycle(8'h00, 8'h20, "t3_stall");
    cr[5] = 1'b1; cycle(8'h00, 8'h20, "t3_credit_ret");
    cr[5] = 1'b0; cycle(8'h04, 8'h20, "t3_one_more");
    flit(2, 1'b0, 1'b1, D_O5);
    cycle(8'h00, 8'h20, "t3_tail_stall");
    cr[5] = 1'b1; cycle(8'h00, 8'h20, "t3_tail_credit");
    cr[5] = 1'b0; cycle(8'h04, 8'h00, "t3_tail_grant");

    // four single-flit requesters on output 1 with credit returned every cycle
    clr();
    for (int i = 0; i < 4; i++) flit(i, 1'b1, 1'b1, D_O1);
    cr[1] = 1'b1;
    for (int n = 0; n < 5; n++) cycle(8'(1 << (n % 4)), 8'h00, "t4_rotate");
    clr();
    chk("t4_err", 64'(err), 64'h0);

    // illegal destports: zero and multi-hot
    flit(3, 1'b1, 1'b1, 5'b0_0000);
    cycle(8'h00, 8'h00, "t5_zero");
    chk("t5_err_zero", 64'(err), 64'h1);
    dp[3] = 5'b0_0101;
    cycle(8'h00, 8'h00, "t5_multi");
    chk("t5_err_multi", 64'(err), 64'h1);
    clr();
    for (int n = 0; n < 2; n++) cycle(8'h00, 8'h00, "t5_idle");
    chk("t5_err_sticky", 64'(err), 64'h1);

    // asynchronous reset in the middle of a locked packet on output 3
    flit(0, 1'b1, 1'b0, D_O3);
    cycle(8'h01, 8'h08, "t6_head");
    flit(0, 1'b0, 1'b0, D_O3);
    cycle(8'h01, 8'h08, "t6_body");
    #2 reset = 1'b0;
    #1;
    chk("t6_async_locked",   64'(out_locked), 64'h0);
    chk("t6_async_valid",    64'(out_valid),  64'h0);
    chk("t6_async_sel",      64'(out_sel),    64'h0);
    chk("t6_async_err",      64'(err),        64'h0);
    chk("t6_async_in_grant", 64'(in_grant),   64'h0);
    model_sel = '0;
    clr();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    flit(1, 1'b1, 1'b0, D_O3);
    cycle(8'h02, 8'h08, "t6_new_head");
    flit(1, 1'b0, 1'b1, D_O3);
    cycle(8'h02, 8'h00, "t6_new_tail");

    // credit returned to a full output is an overflow
    clr();
    chk("t7_err_before", 64'(err), 64'h0);
    cr[7] = 1'b1;
    cycle(8'h00, 8'h00, "t7_overflow");
    chk("t7_err_after", 64'(err), 64'h1);
    clr();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
